bmp_stream_loader: RTL
======================

// Module: bmp_stream_loader
// PURPOSE
//  Sits between data_io (ioctl byte stream, clk_sys domain) and sdram port1 in the MENU core.
//  Parses the BMP header of a download, validates it, and packs pixel bytes into 16-bit sdram
//  write requests at word addresses relative to the pixel-data start. Flags the picture as loaded
//  only after every write is acknowledged. The video path reads the picture back from sdram.
// PARAMETERS
//  ADDR_W      23  sdram word-address width (mem_a)
//  FIFO_DEPTH  4   pending write-word entries (power of 2, >=2)
//  HDR_MIN     30  minimum legal pixel-data offset in bytes
// PORTS
//  clk_sys         in   1       system clock (same clock as data_io clk_sys)
//  reset_n         in   1       asynchronous active-low reset
//  ioctl_download  in   1       download active
//  ioctl_wr        in   1       byte strobe, level; byte taken on its 0->1 edge
//  ioctl_addr      in   25      byte address within file
//  ioctl_dout      in   8       byte data
//  mem_req         out  1       toggle request to sdram port1
//  mem_ack         in   1       toggle ack; equals mem_req when idle
//  mem_a           out  ADDR_W  word address = (byte offset from data start) >> 1
//  mem_d           out  16      {odd byte, even byte}
//  mem_ds          out  2       byte enables: [1]=odd byte, [0]=even byte
//  mem_we          out  1       1 while a request is outstanding
//  data_start      out  24      header bytes 10..12, little-endian
//  bmp_width       out  16      header bytes 18..19
//  bmp_height      out  16      header bytes 22..23
//  bmp_loaded      out  1       picture fully written
//  bmp_error       out  1       sticky until next download start
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; FIFO empty; pending half-word cleared.
//  - FSM states: IDLE, HEADER, PIXELS, DRAIN, DONE, ERROR. A rising edge of ioctl_download in any
//    state goes to HEADER and clears bmp_loaded, bmp_error, FIFO, byte counter and header regs.
//  - HEADER: byte0!=8'h42 or byte1!=8'h4D -> ERROR. Byte 13!=0 -> ERROR. Bytes 28..29 (bpp)
//    !=16'd32 -> ERROR. Bytes 24..25 (height high half) !=0 -> ERROR. After byte 29:
//    data_start<HDR_MIN -> ERROR. Otherwise go to PIXELS and register
//    limit = width*height*4 (32-bit).
//  - Bytes are taken in address order: an accepted byte whose ioctl_addr != previous+1 -> ERROR.
//    Byte 0 is the first byte accepted.
//  - PIXELS: bytes with ioctl_addr < data_start are ignored. For off = ioctl_addr - data_start:
//    off>=limit is ignored; even off is held in the pending half-word; odd off completes a word
//    (ds=2'b11) and pushes {off>>1, d, ds} into the FIFO.
//  - ioctl_download falling: in HEADER -> ERROR; in PIXELS -> push any pending even byte
//    (ds=2'b01, d[15:8]=0) and go to DRAIN. DRAIN -> DONE when the FIFO is empty and
//    mem_req==mem_ack. DONE sets bmp_loaded=1.
//  - Handshake: one request outstanding at a time. When FIFO not empty and mem_req==mem_ack,
//    register head onto mem_a/d/ds, toggle mem_req and set mem_we=1. When mem_ack==mem_req,
//    pop the head and clear mem_we unless the next head issues the same cycle.
//  - Simultaneous FIFO push and pop in one cycle is legal; occupancy unchanged.
//  - Push into a full FIFO: drop the word, go to ERROR.
//  - ERROR: stop issuing new requests; the outstanding request may complete. bmp_loaded stays 0.
//  - Reset mid-transfer: immediate return to reset state. The sdram side is reset together.
// TESTING
//  - Valid 4x2 32bpp BMP, data_start=54, ack 3 cycles after req -> 16 writes; mem_a 0..15 all
//    ds=11; first d={byte55,byte54}; bmp_loaded=1 after last ack; width=4; height=2.
//  - Header with byte0=8'h41 -> bmp_error=1 at byte 0; no mem_req toggle; bmp_loaded stays 0.
//  - bpp=24 -> ERROR after byte 29; no writes issued.
//  - Odd-length pixel tail (limit larger than data received, last off even) -> final write has
//    ds=01 and d[15:8]=0, then DONE.
//  - mem_ack held off for 40 cycles while bytes arrive every 2 cycles -> FIFO fills; overflow sets
//    bmp_error=1; the outstanding write still completes.
//  - reset_n pulsed low mid-PIXELS -> all outputs 0; a new download then loads normally.
//  - Extra bytes beyond limit -> no writes for them.
//  - Second download after DONE -> bmp_loaded drops at start and rises again at end.

Source files
------------

// File: rtl/bmp_stream_loader.sv
// Parses a BMP download from data_io and writes its pixel bytes to sdram port1 as 16-bit words.
// One write in flight at a time; pushes are never stalled, so a full queue drops the word and flags bmp_error.

module bmp_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic [W-1:0] next_dat,
  output logic         empty,
  output logic         full,
  output logic         two_plus
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   occ;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign occ      = wr_ptr - rd_ptr;
  assign empty    = (occ == '0);
  assign full     = (occ == (AW+1)'(DEPTH));
  assign two_plus = (occ >= (AW+1)'(2));
  assign do_pop   = pop_vld && !empty;
  // a push into a full queue still lands when the head leaves in the same cycle
  assign do_push  = push_vld && (!full || do_pop);
  assign rd_nxt   = rd_ptr[AW-1:0] + AW'(1);
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign next_dat = mem[rd_nxt];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module bmp_stream_loader #(
  parameter int ADDR_W     = 23,
  parameter int FIFO_DEPTH = 4,
  parameter int HDR_MIN    = 30
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_a,
  output logic [15:0]       mem_d,
  output logic [1:0]        mem_ds,
  output logic              mem_we,
  output logic [23:0]       data_start,
  output logic [15:0]       bmp_width,
  output logic [15:0]       bmp_height,
  output logic              bmp_loaded,
  output logic              bmp_error
);
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PIXELS, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dat;
    logic [1:0]        ds;
  } wr_ent_t;

  state_t      state;
  state_t      state_nxt;
  logic        dl_q;
  logic        wr_q;
  logic        dl_rise;
  logic        dl_fall;
  logic        take;
  logic        addr_err;
  logic        hdr_byte;
  logic        hdr_err;
  logic        hdr_done;
  logic        pix_byte;
  logic        in_rng;
  logic        pix_push;
  logic        flush_push;
  logic        push_vld;
  logic        ovf;
  logic [24:0] byte_cnt;
  logic [24:0] off;
  logic [31:0] off_w;
  logic [31:0] limit;
  logic [31:0] area;
  logic [7:0]  bpp_lo;

  logic              pend_vld;
  logic [7:0]        pend_dat;
  logic [ADDR_W-1:0] pend_addr;

  wr_ent_t push_dat;
  wr_ent_t head_dat;
  wr_ent_t next_dat;
  wr_ent_t issue_dat;
  logic    q_empty;
  logic    q_full;
  logic    q_two_plus;
  logic    ack_eq;
  logic    hd_issued;
  logic    pop;
  logic    issue;
  logic    issue_en;

  assign dl_rise  = ioctl_download && !dl_q;
  assign dl_fall  = !ioctl_download && dl_q;
  assign take     = ioctl_wr && !wr_q && ioctl_download && !dl_rise &&
                    (state == S_HEADER || state == S_PIXELS);
  assign addr_err = take && (ioctl_addr != byte_cnt);
  assign hdr_byte = take && (state == S_HEADER) && !addr_err;
  assign hdr_done = hdr_byte && (byte_cnt == 25'd29) && !hdr_err;
  assign pix_byte = take && (state == S_PIXELS) && !addr_err;

  assign off    = ioctl_addr - {1'b0, data_start};
  assign off_w  = {7'b0, off};
  assign in_rng = (ioctl_addr >= {1'b0, data_start}) && (off_w < limit);
  assign area   = 32'(bmp_width) * 32'(bmp_height);

  assign pix_push   = pix_byte && in_rng && off[0];
  assign flush_push = dl_fall && (state == S_PIXELS) && pend_vld;
  assign push_vld   = pix_push || flush_push;

  always_comb begin
    hdr_err = 1'b0;
    case (byte_cnt)
      25'd0:                  hdr_err = (ioctl_dout != 8'h42);
      25'd1:                  hdr_err = (ioctl_dout != 8'h4D);
      25'd13, 25'd24, 25'd25: hdr_err = (ioctl_dout != 8'h00);
      25'd29:                 hdr_err = ({ioctl_dout, bpp_lo} != 16'd32) ||
                                        (data_start < 24'(HDR_MIN));
      default:                hdr_err = 1'b0;
    endcase
  end

  always_comb begin
    push_dat = '0;
    if (pix_push) begin
      push_dat.addr = off_w[ADDR_W:1];
      push_dat.dat  = {ioctl_dout, pend_dat};
      push_dat.ds   = 2'b11;
    end else begin
      push_dat.addr = pend_addr;
      push_dat.dat  = {8'h00, pend_dat};
      push_dat.ds   = 2'b01;
    end
  end

  bmp_stream_fifo #(
    .W     ($bits(wr_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .clr      (dl_rise),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop),
    .head_dat (head_dat),
    .next_dat (next_dat),
    .empty    (q_empty),
    .full     (q_full),
    .two_plus (q_two_plus)
  );

  // the head stays queued until acked; on that ack the next entry can go out at once
  assign ack_eq    = (mem_req == mem_ack);
  assign pop       = hd_issued && ack_eq;
  assign ovf       = push_vld && q_full && !pop;
  assign issue     = issue_en && ack_eq && !dl_rise && (hd_issued ? q_two_plus : !q_empty);
  assign issue_dat = hd_issued ? next_dat : head_dat;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q       <= 1'b0;
      wr_q       <= 1'b0;
      byte_cnt   <= '0;
      data_start <= '0;
      bmp_width  <= '0;
      bmp_height <= '0;
      bpp_lo     <= '0;
      limit      <= '0;
      pend_vld   <= 1'b0;
      pend_dat   <= '0;
      pend_addr  <= '0;
    end else begin
      dl_q <= ioctl_download;
      wr_q <= ioctl_wr;
      if (dl_rise) begin
        byte_cnt   <= '0;
        data_start <= '0;
        bmp_width  <= '0;
        bmp_height <= '0;
        bpp_lo     <= '0;
        limit      <= '0;
        pend_vld   <= 1'b0;
      end else begin
        if (take) byte_cnt <= byte_cnt + 25'd1;
        if (hdr_byte) begin
          case (byte_cnt)
            25'd10:  data_start[7:0]   <= ioctl_dout;
            25'd11:  data_start[15:8]  <= ioctl_dout;
            25'd12:  data_start[23:16] <= ioctl_dout;
            25'd18:  bmp_width[7:0]    <= ioctl_dout;
            25'd19:  bmp_width[15:8]   <= ioctl_dout;
            25'd22:  bmp_height[7:0]   <= ioctl_dout;
            25'd23:  bmp_height[15:8]  <= ioctl_dout;
            25'd28:  bpp_lo            <= ioctl_dout;
            default: ;
          endcase
        end
        if (hdr_done) limit <= area << 2;
        if (pix_push || flush_push) begin
          pend_vld <= 1'b0;
        end else if (pix_byte && in_rng && !off[0]) begin
          pend_vld  <= 1'b1;
          pend_dat  <= ioctl_dout;
          pend_addr <= off_w[ADDR_W:1];
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_d     <= '0;
      mem_ds    <= '0;
      hd_issued <= 1'b0;
    end else if (issue) begin
      mem_a     <= issue_dat.addr;
      mem_d     <= issue_dat.dat;
      mem_ds    <= issue_dat.ds;
      mem_req   <= ~mem_req;
      mem_we    <= 1'b1;
      hd_issued <= 1'b1;
    end else begin
      if (ack_eq) mem_we <= 1'b0;
      if (pop || dl_rise) hd_issued <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (dl_rise) begin
      state_nxt = S_HEADER;
    end else begin
      case (state)
        S_HEADER: begin
          if (addr_err || (hdr_byte && hdr_err) || dl_fall) state_nxt = S_ERROR;
          else if (hdr_done)                                state_nxt = S_PIXELS;
        end
        S_PIXELS: begin
          if (addr_err || ovf) state_nxt = S_ERROR;
          else if (dl_fall)    state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          if (q_empty && ack_eq) state_nxt = S_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bmp_loaded = (state == S_DONE);
    bmp_error  = (state == S_ERROR);
    issue_en   = (state != S_ERROR);
  end
endmodule
